combiner_arbiter: RTL and testbench
===================================

// Module: combiner_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer sharing one registered combiner output channel among NUM_REQ
//   valid/ready requesters. Grants one requester at a time for a burst of up to MAX_BURST beats,
//   gated by a global enable. Sits upstream of the signal-combiner output stage and feeds its sink.
// PARAMETERS
//   NUM_REQ    3   number of requesters (>=2)
//   DATA_W     8   beat width in bits
//   MAX_BURST  4   max beats per grant before rotating (>=1)
// PORTS
//   clk         in   1                 clock, all state on rising edge
//   rst_n       in   1                 asynchronous active-low reset
//   enable      in   1                 0 = accept no new beats (drain only)
//   req_valid   in   NUM_REQ           per-requester beat valid
//   req_data    in   NUM_REQ*DATA_W    requester i data at [i*DATA_W +: DATA_W]
//   req_ready   out  NUM_REQ           per-requester accept (one-hot or zero)
//   out_valid   out  1                 output register holds a beat
//   out_data    out  DATA_W            output beat
//   out_src     out  SRC_W             index of requester that produced out_data
//   out_ready   in   1                 sink accepts beat when out_valid && out_ready
//   busy        out  1                 state != IDLE || out_valid
// BEHAVIOUR
//   - Reset: state IDLE, rr_ptr=0, beat_cnt=0, out_valid=0, out_data=0, out_src=0;
//     req_ready=0, busy=0. Async: mid-burst reset drops in-flight beat, no completion.
//   - States: IDLE, GRANT. slot_free = !out_valid || out_ready.
//   - IDLE: if enable && |req_valid: winner = first valid index at/after rr_ptr (wrap mod NUM_REQ);
//     owner<=winner, beat_cnt<=0, -> GRANT. req_ready=0 in IDLE. enable=0 -> stay IDLE.
//   - GRANT: req_ready[owner] = enable && slot_free; others 0. Accept = valid&&ready:
//     out_data<=data, out_src<=owner, out_valid<=1, beat_cnt++.
//   - Grant ends (-> IDLE, rr_ptr<=(owner+1) mod NUM_REQ) when the MAX_BURST-th beat is accepted,
//     or any GRANT cycle with req_valid[owner]=0. enable=0 alone holds GRANT, no accepts.
//   - Output: out_valid clears on out_ready with no same-cycle accept; accept+out_ready reloads
//     (full throughput, 1 beat/cycle). out_data/out_src stable while out_valid && !out_ready.
//   - Latency: req_valid rise in IDLE -> out_valid 2 cycles later (arbitrate, accept).
//   - Rotation costs one IDLE bubble between grants; enable falling never drops a held beat.
// CONFIGURATION
//   COMBINER_ARB_OR_MERGE_EN defined: adds input merge_mode (1 bit). In IDLE with merge_mode &&
//     enable && slot_free && |req_valid: all valid requesters get req_ready=1 same cycle,
//     out_data<=bitwise OR of their data, out_src<=lowest valid index, stay IDLE, rr_ptr unchanged.
//     merge_mode in GRANT ignored until grant ends.
//   Not defined: no merge_mode port, pure round-robin as above.
// STRUCTURE
//   combiner_pkg: state enum (IDLE, GRANT), function src_w(n)=max(1,$clog2(n)), SRC_W usage.
//   Sub-module combiner_rr_pick: combinational valid mask + rr_ptr -> winner index, any_valid.
//   Top holds FSM, beat counter, output register, merge path under ifdef.
// TESTING
//   1 All 3 valid continuously, out_ready=1 -> out_src 0,0,0,0,1,1,1,1,2,2,2,2,0 (one bubble each).
//   2 Only req1 valid, data 0xA5, one beat -> out_valid 2 cycles later, out_data 0xA5, out_src 1;
//     next req0+req2 together -> req2 wins (rr_ptr=2).
//   3 out_ready=0 for 5 cycles mid-burst -> out_data stable, req_ready all 0, no loss/duplication.
//   4 enable=0 after 2 beats of a burst -> no accepts, GRANT held; re-enable -> beats 3,4 then rotate.
//   5 rst_n low mid-burst -> out_valid=0, req_ready=0 immediately; after release req0 wins first.
//   6 (merge) merge_mode=1, req0=0x01, req2=0x80 valid -> req_ready=3'b101 one cycle,
//     out_data 0x81, out_src 0.

Source files
------------

// File: rtl/combiner_pkg.sv
// combiner_pkg: shared state encoding and source-index width helper for the combiner arbiter
package combiner_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic int src_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/combiner_arbiter_if.sv
// combiner_arbiter_if: requester-side and sink-side valid/ready bundle of the combiner arbiter
interface combiner_arbiter_if
    import combiner_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8
) ();

    localparam int SRC_W = src_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;

    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/combiner_rr_pick.sv
// combiner_rr_pick: combinational round-robin pick of the first valid index at/after ptr
module combiner_rr_pick
    import combiner_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int SRC_W   = src_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   winner,
    output logic               any_valid
);

    // Scan the wrapped order backwards so the last write is the nearest valid at/after ptr
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (valid[(int'(ptr) + i) % NUM_REQ]) winner = SRC_W'((int'(ptr) + i) % NUM_REQ);
    end

    assign any_valid = |valid;

endmodule

// File: rtl/combiner_arbiter.sv
// combiner_arbiter: round-robin burst arbiter feeding one registered output channel
// Optional OR-merge path enabled by defining COMBINER_ARB_OR_MERGE_EN.
module combiner_arbiter
    import combiner_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
`ifdef COMBINER_ARB_OR_MERGE_EN
    input  logic                 merge_mode,
`endif
    combiner_arbiter_if.master   bus,
    output logic                 busy
);

    localparam int SRC_W = src_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t             state, state_nx;
    logic [SRC_W-1:0]   owner, rr_ptr, winner;
    logic [CNT_W-1:0]   beat_cnt;
    logic               any_valid, slot_free, accept;
    logic               merge_go;
    logic [DATA_W-1:0]  merge_data;
    logic [SRC_W-1:0]   merge_src;

    combiner_rr_pick #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) u_pick (
        .valid     (bus.req_valid),
        .ptr       (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign slot_free = !bus.out_valid || bus.out_ready;

`ifdef COMBINER_ARB_OR_MERGE_EN
    logic low_any;

    // Lowest valid index is a round-robin pick anchored at zero
    combiner_rr_pick #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) u_low (
        .valid     (bus.req_valid),
        .ptr       ('0),
        .winner    (merge_src),
        .any_valid (low_any)
    );

    assign merge_go = merge_mode && enable && slot_free && low_any;

    // Bitwise OR of every valid requester's beat
    always_comb begin
        merge_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            merge_data = merge_data | (bus.req_valid[i] ? bus.req_data[i*DATA_W +: DATA_W] : '0);
    end
`else
    assign merge_go   = 1'b0;
    assign merge_data = '0;
    assign merge_src  = '0;
`endif

    // Next state, per-requester ready and beat acceptance
    always_comb begin
        state_nx      = state;
        bus.req_ready = '0;
        accept        = 1'b0;
        if (state == IDLE) begin
            if (merge_go) bus.req_ready = bus.req_valid;
            else if (enable && any_valid) state_nx = GRANT;
        end else begin
            bus.req_ready[owner] = enable && slot_free;
            accept = bus.req_valid[owner] && enable && slot_free;
            if (!bus.req_valid[owner] || (accept && beat_cnt == CNT_W'(MAX_BURST - 1)))
                state_nx = IDLE;
        end
    end

    // State, grant bookkeeping and the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == GRANT) begin
                owner    <= winner;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == GRANT && state_nx == IDLE)
                rr_ptr <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.req_data[int'(owner)*DATA_W +: DATA_W];
                bus.out_src   <= owner;
            end else if (merge_go) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= merge_data;
                bus.out_src   <= merge_src;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE) || bus.out_valid;

endmodule

// File: tb/tb_combiner_arbiter.sv
// tb_combiner_arbiter: directed self-checking bench for combiner_arbiter
module tb_combiner_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic busy;
`ifdef COMBINER_ARB_OR_MERGE_EN
    logic merge_mode;
`endif
    int checks = 0;
    int errors = 0;

    combiner_arbiter_if #(.NUM_REQ(3), .DATA_W(8)) bus ();

    combiner_arbiter #(.NUM_REQ(3), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
`ifdef COMBINER_ARB_OR_MERGE_EN
        .merge_mode (merge_mode),
`endif
        .bus        (bus.master),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int seq [17] = '{-1, 0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 2, 2, 2, 2, -1, 0};

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
`ifdef COMBINER_ARB_OR_MERGE_EN
        merge_mode    = 1'b0;
`endif
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_src", 32'(bus.out_src), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // all requesters valid: 4-beat bursts rotating with one bubble
        bus.req_data  = {8'h30, 8'h20, 8'h10};
        bus.req_valid = 3'b111;
        enable        = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            check("t1_valid", 32'(bus.out_valid), 32'(seq[k] >= 0));
            if (seq[k] >= 0) begin
                check("t1_src", 32'(bus.out_src), 32'(seq[k]));
                check("t1_data", 32'(bus.out_data), 32'(16 * (seq[k] + 1)));
            end
        end
        bus.req_valid = '0;
        tick();
        tick();
        check("t1_idle_busy", 32'(busy), 0);

        // single req1 beat, latency 2, then req2 beats req0 via rr_ptr
        bus.req_data[15:8] = 8'hA5;
        bus.req_valid      = 3'b010;
        tick();
        check("t2_lat1_valid", 32'(bus.out_valid), 0);
        check("t2_grant1", 32'(bus.req_ready), 3'b010);
        tick();
        check("t2_valid", 32'(bus.out_valid), 1);
        check("t2_data", 32'(bus.out_data), 'hA5);
        check("t2_src", 32'(bus.out_src), 1);
        bus.req_valid     = 3'b101;
        bus.req_data[7:0] = 8'h01;
        bus.req_data[23:16] = 8'h02;
        tick();
        check("t2_drain", 32'(bus.out_valid), 0);
        tick();
        check("t2_grant2", 32'(bus.req_ready), 3'b100);
        tick();
        check("t2_src2", 32'(bus.out_src), 2);
        check("t2_data2", 32'(bus.out_data), 'h02);
        bus.req_valid = '0;
        tick();
        tick();

        // sink stall mid-burst
        bus.req_data[7:0] = 8'h40;
        bus.req_valid     = 3'b001;
        tick();
        check("t3_grant0", 32'(bus.req_ready), 3'b001);
        tick();
        check("t3_b1", 32'(bus.out_data), 'h40);
        bus.req_data[7:0] = 8'h41;
        tick();
        check("t3_b2", 32'(bus.out_data), 'h41);
        bus.req_data[7:0] = 8'h42;
        bus.out_ready     = 1'b0;
        #1;
        check("t3_stall_ready", 32'(bus.req_ready), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_hold_valid", 32'(bus.out_valid), 1);
            check("t3_hold_data", 32'(bus.out_data), 'h41);
            check("t3_hold_ready", 32'(bus.req_ready), 0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("t3_resume_ready", 32'(bus.req_ready), 3'b001);
        tick();
        check("t3_b3", 32'(bus.out_data), 'h42);
        bus.req_data[7:0] = 8'h43;
        tick();
        check("t3_b4", 32'(bus.out_data), 'h43);
        bus.req_valid = '0;
        tick();
        check("t3_end_valid", 32'(bus.out_valid), 0);
        check("t3_end_busy", 32'(busy), 0);

        // enable drop after two beats holds the grant
        bus.req_data[15:8]  = 8'h50;
        bus.req_data[23:16] = 8'h60;
        bus.req_valid       = 3'b110;
        tick();
        check("t4_grant1", 32'(bus.req_ready), 3'b010);
        tick();
        check("t4_b1", 32'(bus.out_data), 'h50);
        bus.req_data[15:8] = 8'h51;
        tick();
        check("t4_b2", 32'(bus.out_data), 'h51);
        bus.req_data[15:8] = 8'h52;
        enable = 1'b0;
        #1;
        check("t4_dis_ready", 32'(bus.req_ready), 0);
        tick();
        check("t4_dis_valid", 32'(bus.out_valid), 0);
        check("t4_dis_busy", 32'(busy), 1);
        tick();
        check("t4_hold_busy", 32'(busy), 1);
        tick();
        check("t4_hold_valid", 32'(bus.out_valid), 0);
        enable = 1'b1;
        #1;
        check("t4_reen_ready", 32'(bus.req_ready), 3'b010);
        tick();
        check("t4_b3", 32'(bus.out_data), 'h52);
        check("t4_b3_src", 32'(bus.out_src), 1);
        bus.req_data[15:8] = 8'h53;
        tick();
        check("t4_b4", 32'(bus.out_data), 'h53);
        tick();
        check("t4_bubble", 32'(bus.out_valid), 0);
        check("t4_rotate", 32'(bus.req_ready), 3'b100);
        tick();
        check("t4_src2", 32'(bus.out_src), 2);
        check("t4_data2", 32'(bus.out_data), 'h60);
        bus.req_valid = '0;
        tick();
        tick();

        // async reset mid-burst restarts rotation at req0
        bus.req_data[15:8] = 8'h70;
        bus.req_valid      = 3'b010;
        tick();
        tick();
        check("t5_pre_src", 32'(bus.out_src), 1);
        bus.req_valid       = 3'b100;
        bus.req_data[23:16] = 8'h71;
        tick();
        tick();
        check("t5_grant2", 32'(bus.req_ready), 3'b100);
        tick();
        check("t5_mid_src", 32'(bus.out_src), 2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus.out_valid), 0);
        check("t5_rst_ready", 32'(bus.req_ready), 0);
        check("t5_rst_busy", 32'(busy), 0);
        bus.req_data[7:0] = 8'h01;
        bus.req_valid     = 3'b111;
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_first_grant", 32'(bus.req_ready), 3'b001);
        tick();
        check("t5_first_src", 32'(bus.out_src), 0);
        check("t5_first_data", 32'(bus.out_data), 'h01);
        bus.req_valid = '0;
        tick();
        tick();

`ifdef COMBINER_ARB_OR_MERGE_EN
        // OR-merge of req0 and req2 in one cycle
        merge_mode          = 1'b1;
        bus.req_data[7:0]   = 8'h01;
        bus.req_data[23:16] = 8'h80;
        bus.req_valid       = 3'b101;
        #1;
        check("t6_ready", 32'(bus.req_ready), 3'b101);
        tick();
        check("t6_valid", 32'(bus.out_valid), 1);
        check("t6_data", 32'(bus.out_data), 'h81);
        check("t6_src", 32'(bus.out_src), 0);
        bus.req_valid = '0;
        merge_mode    = 1'b0;
        tick();
        check("t6_drain", 32'(bus.out_valid), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
